// File: rtl/anc_flag_pkg.sv
// Shared constants for the ANC event-flag bank: how a channel resolves
// simultaneous set and reset requests.
package anc_flag_pkg;

    localparam int PRIO_RESET  = 0;
    localparam int PRIO_SET    = 1;
    localparam int PRIO_TOGGLE = 2;

endpackage

// File: rtl/rs_flag_cell.sv
// One flag channel: the set/reset flag, its retriggerable auto-clear
// counter, and registered Rise/Fall/Expired pulses aligned with the new Q.
module rs_flag_cell
    import anc_flag_pkg::*;
#(
    parameter int PRIORITY    = PRIO_RESET,
    parameter int HOLD_CYCLES = 0,
    parameter int CNT_W       = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic S,
    input  logic R,
    input  logic Clr_all,
    output logic Q,
    output logic Rise,
    output logic Fall,
    output logic Expired
);

    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             qNext;
    logic             load;
    logic             expire;

    // Next-state choice, highest priority first; load marks edges where S
    // is the reason Q ends up 1, which is what restarts the timeout.
    always_comb begin
        qNext  = Q;
        load   = 1'b0;
        expire = 1'b0;
        if (Clr_all) begin
            qNext = 1'b0;
        end else if (S && R) begin
            case (PRIORITY)
                PRIO_SET: begin
                    qNext = 1'b1;
                    load  = 1'b1;
                end
                PRIO_TOGGLE: begin
                    qNext = ~Q;
                    load  = ~Q;
                end
                default: qNext = 1'b0;
            endcase
        end else if (R) begin
            qNext = 1'b0;
        end else if (S) begin
            qNext = 1'b1;
            load  = 1'b1;
        end else if (HOLD_CYCLES > 0 && Q && cnt == CNT_W'(1)) begin
            qNext  = 1'b0;
            expire = 1'b1;
        end

        if (!qNext || HOLD_CYCLES == 0) begin
            cntNext = '0;
        end else if (load) begin
            cntNext = HOLD;
        end else if (cnt != '0) begin
            cntNext = cnt - CNT_W'(1);
        end else begin
            cntNext = cnt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Q       <= 1'b0;
            Rise    <= 1'b0;
            Fall    <= 1'b0;
            Expired <= 1'b0;
            cnt     <= '0;
        end else begin
            Q       <= qNext;
            Rise    <= qNext & ~Q;
            Fall    <= ~qNext & Q;
            Expired <= expire;
            cnt     <= cntNext;
        end
    end

endmodule

// File: rtl/rs_flag_bank.sv
// Bank of independent set/reset event flags with edge pulses and
// Any/Count summaries for the ANC control FSMs.
module rs_flag_bank
    import anc_flag_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int PRIORITY    = PRIO_RESET,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [CHANNELS-1:0]           S,
    input  logic [CHANNELS-1:0]           R,
    input  logic                          Clr_all,
    output logic [CHANNELS-1:0]           Q,
    output logic [CHANNELS-1:0]           Rise,
    output logic [CHANNELS-1:0]           Fall,
    output logic [CHANNELS-1:0]           Expired,
    output logic                          Any,
    output logic [$clog2(CHANNELS+1)-1:0] Count
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int CW    = $clog2(CHANNELS + 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : gCell
        rs_flag_cell #(
            .PRIORITY    (PRIORITY),
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
        ) uCell (
            .Clk     (Clk),
            .Rst     (Rst),
            .S       (S[i]),
            .R       (R[i]),
            .Clr_all (Clr_all),
            .Q       (Q[i]),
            .Rise    (Rise[i]),
            .Fall    (Fall[i]),
            .Expired (Expired[i])
        );
    end

    assign Any = |Q;

    // Popcount straight off the flag registers, so Count tracks Q with no lag.
    always_comb begin
        Count = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            Count = Count + CW'(Q[i]);
        end
    end

endmodule

// File: doc/rs_flag_bank.md
# rs_flag_bank

Parametrised multi-channel set/reset flag register, the next generation of the single-bit RS flip-flop used across the ANC datapath for event flags: sample-ready, adaptation-enable, overflow and similar. Each channel is a clocked set/reset flag with a selectable collision mode and an optional retriggerable auto-clear timeout. The bank adds edge pulses, a global clear and summary outputs, so control FSMs in the ANC top level can consume flags without their own edge detectors.

## Interface
- CHANNELS, 4: number of independent flag channels (1..32).
- PRIORITY, 0: behaviour when S and R are both high. 0 = reset-dominant, 1 = set-dominant, 2 = toggle.
- HOLD_CYCLES, 0: auto-clear timeout in clock cycles (0 = disabled, else 1..65535).
- CNT_W, derived: $clog2(HOLD_CYCLES+1), minimum 1. Not for override.
- Clk  in  1  system clock; all state changes on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- S  in  CHANNELS  per-channel set request, sampled each rising edge.
- R  in  CHANNELS  per-channel reset request, sampled each rising edge.
- Clr_all  in  1  synchronous clear of every channel.
- Q  out  CHANNELS  registered flag state.
- Rise  out  CHANNELS  one-cycle pulse, registered, high in the first cycle Q[i] is 1 after being 0.
- Fall  out  CHANNELS  one-cycle pulse, registered, high in the first cycle Q[i] is 0 after being 1.
- Expired  out  CHANNELS  one-cycle pulse, registered, high alongside Fall[i] when the clear was caused by the timeout.
- Any  out  1  OR of Q, combinational from registers.
- Count  out  $clog2(CHANNELS+1)  number of set flags, combinational popcount of Q.

## Operation
- Per channel, next state is chosen by priority, highest first:
  - Rst: Q=0.
  - Clr_all: Q=0.
  - S/R collision: resolved per PRIORITY. Mode 2 inverts Q.
  - R alone: Q=0.
  - S alone: Q=1.
  - Timeout expiry: Q=0.
  - Otherwise: hold.
- Timeout applies only when HOLD_CYCLES>0. The channel counter loads HOLD_CYCLES on every edge where the next Q is 1 because of S, including S while Q is already 1 (retrigger). A toggle to 1 in mode 2 also loads the counter.
- While Q=1 and no load occurs, the counter decrements by 1 per edge. When it reaches 1 and no S/R/Clr_all is present, the next edge clears Q and pulses Expired.
- S on the expiry edge reloads the counter and keeps Q=1. No Fall or Expired pulse is produced in that case.
- R, collision-to-0 or Clr_all on the expiry edge produce Fall only; Expired stays 0.
- Counters are forced to 0 whenever Q is 0.
- Rise[i] = next Q & ~Q. Fall[i] = ~next Q & Q. Both are registered with Q, so they coincide with the new Q value.
- Clr_all: Fall pulses for every channel that was set. Expired stays 0.
- Rst: all outputs go to 0 on the next edge: Q=0, Rise=0, Fall=0, Expired=0, Any=0, Count=0. No Fall pulses are generated by reset.

## Timing
- S/R to Q latency: 1 edge. S high for cycle k means Q=1 and Rise=1 from edge k+1.
- With HOLD_CYCLES=N and a single S pulse, Q stays high for exactly N cycles. Q falls at the N-th edge after the set edge.
- Retrigger at edge j moves the fall to edge j+N.
- Rise, Fall and Expired are each high for exactly one cycle.
- Any and Count follow Q in the same cycle, with no added latency.
- Reset mid-timeout discards the count. After Rst deasserts, the channel is idle until the next S.
- Channels are fully independent. Any mix of simultaneous events across channels is legal.

## Structure
- Shared package anc_flag_pkg holds the collision-mode constants: PRIO_RESET=0, PRIO_SET=1, PRIO_TOGGLE=2.
- Sub-module rs_flag_cell holds one channel: flag register, timeout counter, and Rise/Fall/Expired registers. It takes the PRIORITY, HOLD_CYCLES and CNT_W parameters.
- The top level generates CHANNELS cells and adds the Any/Count reduction.
- With CHANNELS=1, HOLD_CYCLES=0 and PRIORITY=0, the bank reproduces the legacy flip-flop behaviour, with the addition of Rst and the edge outputs.

## Test plan
- Reset and collision, PRIORITY=0, CHANNELS=4: Rst, then S=4'b0011, then R=4'b0001 → Q=0011 then 0010; Rise=0011 then 0000; Fall=0001 on the second edge. Then S=R=4'b0010 → Q=0000.
- Collision in the other modes: same S=R stimulus with PRIORITY=1 → Q holds 1. With PRIORITY=2, applied twice from Q=0 → Q = 1 then 0, with Rise then Fall pulses.
- Timeout, HOLD_CYCLES=5: one-cycle S[0] → Q[0] high for exactly 5 cycles; Fall[0]=Expired[0]=1 on the falling cycle.
- Retrigger, HOLD_CYCLES=5: S[0] again 3 cycles after the set → Q[0] high for 8 cycles total. S on the expiry edge → no Fall/Expired, and Q stays high for 5 more cycles.
- Clr_all with channels 0 and 2 set and channel 2 mid-timeout → Q=0000, Fall=0101, Expired=0000. Simultaneous S[1] with Clr_all → Q[1] stays 0.
- Summary outputs, CHANNELS=8, Q=8'b1011_0001 → Any=1, Count=4. Rst asserted mid-operation → all outputs 0 next cycle, no Fall pulses.
